// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32 load/store memory port with alignment check, req/gnt/rvalid handshake and timeout
// Ports: clk, rst_n (async, active-low); req_* from execute; busy/done/err_* status;
//        readdata/d_select/funct3 to the load slicer; mem_* data memory bus.
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic [31:0] readdata,
  output logic [1:0]  d_select,
  output logic [2:0]  funct3,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = TIMEOUT_CYCLES != 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, err_mis_q, err_mis_d, err_to_q, err_to_d;
  logic [2:0] req_f3_q, req_f3_d, out_f3_q, out_f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
  logic [1:0] dsel_q, dsel_d, size;
  logic illegal, accept, take, timeout, load_done;
  logic [3:0] be_new;
  logic [31:0] wd_new;
  always_comb begin
    size = req_funct3[1:0];
    illegal = (size == 2'b11) | (size == 2'b01 & req_addr[0]) |
              (size == 2'b10 & |req_addr[1:0]) | (req_we & req_funct3[2]);
    accept = state_q == IDLE & req_valid;
    take = accept & !illegal;
    // the awaited event (gnt in REQ, rvalid in WAIT) always wins over expiry
    timeout = TO_EN & cnt_q == LAST &
              ((state_q == REQ & !mem_gnt) | (state_q == WAIT & !mem_rvalid));
    load_done = state_q == WAIT & mem_rvalid & !we_q;
    be_new = !req_we ? 4'b1111 :
             size == 2'b00 ? 4'b0001 << req_addr[1:0] :
             size == 2'b01 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
    wd_new = !req_we ? 32'h0 :
             size == 2'b00 ? {4{req_wdata[7:0]}} :
             size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !req_valid ? IDLE : illegal ? DONE : REQ;
      REQ:  state_d = mem_gnt ? WAIT : timeout ? DONE : REQ;
      WAIT: state_d = (mem_rvalid | timeout) ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == REQ | state_q == WAIT) ? cnt_q + CW'(1) : '0;
    we_d = take ? req_we : we_q;
    req_f3_d = take ? req_funct3 : req_f3_q;
    addr_d = take ? req_addr : addr_q;
    be_d = take ? be_new : be_q;
    wdata_d = take ? wd_new : wdata_q;
    rdata_d = load_done ? mem_rdata : rdata_q;
    dsel_d = load_done ? addr_q[1:0] : dsel_q;
    out_f3_d = load_done ? req_f3_q : out_f3_q;
    err_mis_d = accept & illegal;
    err_to_d = timeout;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      req_f3_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dsel_q <= '0;
      out_f3_q <= '0;
      err_mis_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      req_f3_q <= req_f3_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dsel_q <= dsel_d;
      out_f3_q <= out_f3_d;
      err_mis_q <= err_mis_d;
      err_to_q <= err_to_d;
    end
  end
  assign busy = accept | state_q == REQ | state_q == WAIT;
  assign done = state_q == DONE;
  assign err_misaligned = err_mis_q;
  assign err_timeout = err_to_q;
  assign readdata = rdata_q;
  assign d_select = dsel_q;
  assign funct3 = out_f3_q;
  assign mem_req = state_q == REQ;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_we = we_q;
  assign mem_be = be_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: vector table plus scoreboard of completion results for lsu_mem_port
module tb_lsu_mem_port;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic busy, done, err_misaligned, err_timeout, mem_req, mem_we;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic [1:0] d_select;
  logic [2:0] funct3;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  typedef struct {
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata;
    int gd, rd;
    logic mis;
    logic [3:0] be;
    logic [31:0] wd;
  } vec_t;
  typedef struct {
    logic mis, to;
    logic [31:0] rd;
    logic [1:0] ds;
    logic [2:0] f3;
  } exp_t;
  vec_t vecs[12];
  exp_t sb[$];
  logic [31:0] m_rd = 0;
  logic [1:0] m_ds = 0;
  logic [2:0] m_f3 = 0;
  lsu_mem_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err_misaligned(err_misaligned), .err_timeout(err_timeout),
    .readdata(readdata), .d_select(d_select), .funct3(funct3),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic mis, input logic to);
    exp_t e;
    e.mis = mis;
    e.to = to;
    e.rd = m_rd;
    e.ds = m_ds;
    e.f3 = m_f3;
    sb.push_back(e);
  endtask
  task automatic sb_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got completion expected none queued", name);
      return;
    end
    e = sb.pop_front();
    chk({name, ".err_mis"}, err_misaligned, e.mis);
    chk({name, ".err_to"}, err_timeout, e.to);
    chk({name, ".readdata"}, readdata, e.rd);
    chk({name, ".d_select"}, d_select, e.ds);
    chk({name, ".funct3"}, funct3, e.f3);
  endtask
  task automatic check_bus(input vec_t v);
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
    chk("mem_be", mem_be, v.be);
    chk("mem_wdata", mem_wdata, v.wd);
    chk("mem_we", mem_we, v.we);
    chk("busy_req", busy, 1);
    chk("done_early", done, 0);
  endtask
  task automatic scramble();
    req_valid = 0;
    req_we = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask
  task automatic run_vec(input vec_t v);
    req_valid = 1;
    req_we = v.we;
    req_funct3 = v.f3;
    req_addr = v.addr;
    req_wdata = v.wdata;
    #1 chk("busy_accept", busy, 1);
    if (!v.mis && !v.we) begin
      m_rd = v.rdata;
      m_ds = v.addr[1:0];
      m_f3 = v.f3;
    end
    push(v.mis, 0);
    @(negedge clk);
    scramble();
    if (v.mis) begin
      #1 chk("mis_done", done, 1);
      chk("mis_no_req", mem_req, 0);
      chk("mis_busy", busy, 0);
      sb_check("mis");
    end else begin
      for (int i = 0; i < v.gd; i++) begin
        check_bus(v);
        @(negedge clk);
      end
      mem_gnt = 1;
      check_bus(v);
      @(negedge clk);
      mem_gnt = 0;
      chk("req_drop", mem_req, 0);
      for (int i = 0; i < v.rd; i++) begin
        chk("busy_wait", busy, 1);
        chk("done_wait", done, 0);
        @(negedge clk);
      end
      mem_rvalid = 1;
      mem_rdata = v.rdata;
      chk("busy_rsp", busy, 1);
      @(negedge clk);
      mem_rvalid = 0;
      mem_rdata = $urandom;
      #1 chk("done", done, 1);
      chk("busy_done", busy, 0);
      sb_check("access");
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("err_clear", err_misaligned | err_timeout, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h203, 32'hA5, 32'h0, 0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5};
    vecs[2]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h302, 32'h0, 32'h12345678, 4, 2, 1'b0, 4'b1111, 32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h206, 32'h1234BEEF, 32'h0, 1, 0, 1'b0, 4'b1100, 32'hBEEFBEEF};
    vecs[6]  = '{1'b1, 3'b010, 32'h20C, 32'hCAFEF00D, 32'h0, 1, 1, 1'b0, 4'b1111, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0, 32'h0};
    vecs[8]  = '{1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'b000, 32'h001, 32'h0, 32'h11223344, 0, 1, 1'b0, 4'b1111, 32'h0};
    vecs[10] = '{1'b1, 3'b000, 32'h201, 32'h77, 32'h0, 2, 0, 1'b0, 4'b0010, 32'h77777777};
    vecs[11] = '{1'b0, 3'b100, 32'h003, 32'h0, 32'h55667788, 2, 1, 1'b0, 4'b1111, 32'h0};
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_readdata", readdata, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);
    // timeout: no grant ever, abort on the 8th REQ cycle
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h400;
    push(0, 1);
    @(negedge clk);
    scramble();
    for (int i = 0; i < 8; i++) begin
      chk("to_req", mem_req, 1);
      chk("to_done", done, 0);
      @(negedge clk);
    end
    chk("to_fire", done, 1);
    chk("to_req_low", mem_req, 0);
    sb_check("timeout");
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_rvalid = 0;
    chk("stray_done", done, 0);
    chk("stray_rd", readdata, m_rd);
    // rvalid coinciding with grant is not a response
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h600;
    m_rd = 32'h0F0F1234; m_ds = 0; m_f3 = 3'b010;
    push(0, 0);
    @(negedge clk);
    scramble();
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 0;
    chk("gr_busy", busy, 1);
    chk("gr_done", done, 0);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h0F0F1234;
    @(negedge clk);
    mem_rvalid = 0;
    chk("gr_fire", done, 1);
    sb_check("grant_rvalid");
    @(negedge clk);
    // reset during WAIT
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(negedge clk);
    scramble();
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    rst_n = 0;
    #1 chk("ar_mem_req", mem_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_mem_be", mem_be, 0);
    chk("ar_readdata", readdata, 0);
    chk("ar_funct3", funct3, 0);
    m_rd = 0; m_ds = 0; m_f3 = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_vec('{1'b0, 3'b010, 32'h504, 32'h0, 32'hA5A55A5A, 0, 0, 1'b0, 4'b1111, 32'h0});
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit memory port for the RV32 core. It accepts one load or store per request from the execute stage and checks its alignment. It runs a request/grant/response handshake with data memory and stalls the pipeline while the access is in flight. On load completion it presents the raw memory word, byte offset and funct3, registered, to the load data slicer directly downstream.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before abort; 0 disables the timeout.

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents an access
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  effective byte address from ALU
- req_wdata  in  32  store data (rs2)
- busy  out  1  pipeline stall, combinational
- done  out  1  one-cycle completion pulse
- err_misaligned  out  1  valid with done; alignment/size fault, no bus access made
- err_timeout  out  1  valid with done; memory did not respond
- readdata  out  32  raw memory word of last completed load
- d_select  out  2  req_addr[1:0] of last completed load
- funct3  out  3  req_funct3 of last completed load
- mem_req  out  1  bus request
- mem_gnt  in  1  bus grant
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data / write acknowledge
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - req_valid with a legal access: latch we, funct3, addr, be, wdata; go to REQ.
  - Illegal access: go to DONE with err_misaligned set.
- Illegal access, using size = funct3[1:0]:
  - size 11;
  - H with addr[0]=1;
  - W with addr[1:0]≠00;
  - store with funct3[2]=1.
- REQ: mem_req=1, with addr/we/be/wdata held stable. On mem_gnt go to WAIT.
- WAIT: on mem_rvalid go to DONE.
  - Loads latch readdata←mem_rdata, d_select←addr[1:0], funct3←funct3.
  - Stores leave readdata/d_select/funct3 unchanged.
- DONE: done=1 for exactly one cycle, then IDLE. A request is never accepted in DONE.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
  - All loads: 4'b1111.
- mem_wdata:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
  - Loads: 0.
- Timeout:
  - An 8-bit+ counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - Counter == TIMEOUT_CYCLES-1 without the awaited event: go to DONE with err_timeout, and mem_req drops.
  - mem_rvalid arriving in IDLE/DONE is ignored.
- Each accepted request yields exactly one done pulse; err flags are 0 except in that cycle.

## Timing
- Reset (async, any state): state IDLE, counter 0. Outputs:
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0;
  - done=0, err_*=0;
  - readdata=0, d_select=0, funct3=0.
- Reset mid-transaction aborts the transaction; mem_req falls immediately.
- busy = (state==IDLE & req_valid) | state==REQ | state==WAIT. It is 0 in DONE, so the pipeline advances the cycle done is high.
- mem_rvalid is sampled only in WAIT. An rvalid in the grant cycle is not a response; memory latency is ≥1 cycle after gnt.
- Zero-wait memory (gnt in first REQ cycle, rvalid next cycle):
  - accept cycle 0, mem_req cycle 1, WAIT cycle 2, done cycle 3;
  - readdata valid from cycle 3 until the next load completes.
- Misaligned access: done+err_misaligned in cycle 1, and mem_req is never asserted.
- mem_req deasserts in the cycle after gnt. Back-to-back requests are separated by at least one IDLE cycle.

## Test plan
- Load W, addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF: done at cycle 3. readdata=0xDEADBEEF, d_select=00, funct3=010, mem_addr=0x100, mem_be=1111.
- Store B, addr 0x203, wdata 0x000000A5: mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, mem_addr=0x200. readdata unchanged.
- Load H at 0x101: err_misaligned+done at cycle 1, mem_req never 1. Load W at 0x102 behaves the same.
- Load HU at 0x302, gnt delayed 4 cycles, rvalid delayed 3 more:
  - mem_req held stable for the 4 gnt-wait cycles;
  - busy high throughout;
  - done once, with d_select=10 and funct3=101.
- TIMEOUT_CYCLES=8, gnt never given: err_timeout+done 8 cycles after REQ entry, mem_req low after. A later rvalid is ignored.
- rst_n low during WAIT: all outputs return to reset values asynchronously. A subsequent load completes normally.
